// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, condition
// selectors and condition-code bit positions.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    CND_AL = 3'd0,
    CND_LE = 3'd1,
    CND_LT = 3'd2,
    CND_EQ = 3'd3,
    CND_NE = 3'd4,
    CND_GE = 3'd5,
    CND_GT = 3'd6,
    CND_NV = 3'd7
  } cond_e;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RST = 3'b100;

endpackage

// File: rtl/alu_cond.sv
// Condition evaluator: maps a condition
// selector onto the {ZF,SF,OF} code register.
import alu_pkg::*;

module alu_cond (
  input  logic [2:0] cond_fn,
  input  logic [2:0] cc,
  output logic       cond_true
);

  logic zf;
  logic sf;
  logic of_f;
  logic lt;

  // Signed-compare style decode of the codes
  always_comb begin
    zf        = cc[CC_ZF];
    sf        = cc[CC_SF];
    of_f      = cc[CC_OF];
    lt        = sf ^ of_f;
    cond_true = 1'b0;
    unique case (cond_e'(cond_fn))
      CND_AL: cond_true = 1'b1;
      CND_LE: cond_true = lt | zf;
      CND_LT: cond_true = lt;
      CND_EQ: cond_true = zf;
      CND_NE: cond_true = ~zf;
      CND_GE: cond_true = ~lt;
      CND_GT: cond_true = ~lt & ~zf;
      CND_NV: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_cc.sv
// One-stage ALU with valid/ready output
// register and a condition-code register.
import alu_pkg::*;

module alu_pipe_cc #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       control,
  input  logic             set_cc,
  input  logic [2:0]       cond_fn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic [2:0]       cc,
  output logic             cond_true
);

  alu_op_e          op;
  logic             accept;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] res_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             valid_d;
  logic             valid_q;
  logic [2:0]       cc_d;
  logic [2:0]       cc_q;

  assign op       = alu_op_e'(control);
  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  assign out_valid = valid_q;
  assign out       = res_q;
  assign overflow  = ovf_q;
  assign cc        = cc_q;

  // Datapath, overflow detect and next-state
  always_comb begin
    sa    = in1[WIDTH-1];
    sb    = in2[WIDTH-1];
    res_d = '0;
    ovf_d = 1'b0;
    unique case (op)
      ALU_ADD: begin
        res_d = in1 + in2;
        ovf_d = (sa == sb) &&
                (res_d[WIDTH-1] != sa);
      end
      ALU_SUB: begin
        res_d = in1 - in2;
        ovf_d = (sa != sb) &&
                (res_d[WIDTH-1] != sa);
      end
      ALU_AND: res_d = in1 & in2;
      ALU_XOR: res_d = in1 ^ in2;
    endcase

    valid_d = valid_q;
    if (accept)
      valid_d = 1'b1;
    else if (out_ready)
      valid_d = 1'b0;

    cc_d = cc_q;
    if (accept && set_cc) begin
      cc_d[CC_ZF] = (res_d == '0);
      cc_d[CC_SF] = res_d[WIDTH-1];
      cc_d[CC_OF] = ovf_d;
    end
  end

  // Result and condition-code registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      cc_q    <= CC_RST;
    end else begin
      valid_q <= valid_d;
      cc_q    <= cc_d;
      if (accept) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
      end
    end
  end

  alu_cond u_cond (
    .cond_fn   (cond_fn),
    .cc        (cc_q),
    .cond_true (cond_true)
  );

endmodule

// File: doc/alu_pipe_cc.md
ALU_PIPE_CC -- requirements
Module: alu_pipe_cc

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/result width in bits, legal range 8..64.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: operation offered.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operation this cycle.
REQ-006 SHALL have ports in1 and in2, input, WIDTH: operands.
REQ-007 SHALL have port control, input, 2: 00 add, 01 sub, 10 AND, 11 XOR.
REQ-008 SHALL have port set_cc, input, 1: update condition codes with this operation.
REQ-009 SHALL have port cond_fn, input, 3: condition selector, combinational query.
REQ-010 SHALL have port out_valid, output, 1: result register holds an undelivered result.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the result this cycle.
REQ-012 SHALL have port out, output, WIDTH: registered result.
REQ-013 SHALL have port overflow, output, 1: registered signed overflow of that result.
REQ-014 SHALL have port cc, output, 3: {ZF,SF,OF} condition-code register.
REQ-015 SHALL have port cond_true, output, 1: cond_fn evaluated against cc.

Function
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-017 SHALL accept an operation on a rising edge where in_valid && in_ready.
REQ-018 SHALL present the accepted result on out/overflow with out_valid=1 one cycle after acceptance; latency is exactly 1.
REQ-019 SHALL compute add as in1+in2, sub as in1-in2, both modulo 2^WIDTH.
REQ-020 SHALL compute AND and XOR bitwise.
REQ-021 SHALL set overflow for add when the operands share a sign and the result sign differs.
REQ-022 SHALL set overflow for sub when the operand signs differ and the result sign differs from in1.
REQ-023 SHALL force overflow=0 for AND and XOR.
REQ-024 SHALL hold out, overflow and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid after a handshake when no new operation is accepted on the same edge.
REQ-026 SHALL, on simultaneous drain and accept, load the new result and keep out_valid=1 with no bubble.
REQ-027 SHALL update cc only on an accepted operation with set_cc=1: ZF=(result==0), SF=result[WIDTH-1], OF=overflow.
REQ-028 SHALL update cc on the same edge as the result register.
REQ-029 SHALL leave cc unchanged when set_cc=0 or the operation is not accepted.
REQ-030 SHALL evaluate cond_true from the registered cc: 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7 always 0.
REQ-031 SHALL base cond_true on cc before an operation accepted in the same cycle.
REQ-032 SHALL ignore control, operands and set_cc when in_valid=0.

Reset
REQ-033 SHALL, while rst_n=0, force out_valid=0, out=0, overflow=0 and cc=3'b100 (ZF=1, SF=0, OF=0), independent of clk.
REQ-034 SHALL discard any in-flight result asserted mid-operation; in_ready SHALL be 1 during reset.
REQ-035 SHALL accept its first operation on the first rising edge after rst_n deasserts.

Structure
REQ-036 SHALL take ALU opcode encodings, cond_fn encodings and CC bit indices from shared package alu_pkg.
REQ-037 SHALL implement the REQ-030 evaluator as combinational sub-module alu_cond.

Verification
REQ-038 SHALL cover add 20+30, set_cc=1, WIDTH=64 -> next cycle out=50, overflow=0, cc=000; cond_fn=4 -> cond_true=1.
REQ-039 SHALL cover sub 10-10, set_cc=1 -> out=0, cc=100; then add 0x7FFF_FFFF_FFFF_FFFF+1, set_cc=0 -> out=0x8000_0000_0000_0000, overflow=1, cc still 100.
REQ-040 SHALL cover sub with in1=0x8000_0000_0000_0000, in2=1, set_cc=1 -> out=0x7FFF_FFFF_FFFF_FFFF, overflow=1, cc=001; cond_fn=2 -> cond_true=1; cond_fn=6 -> 0.
REQ-041 SHALL cover out_ready=0 for 3 cycles after AND 1011&1100 -> out=1000 held, in_ready=0; then out_ready=1 with new XOR 1011001^1010010 -> out=0001011 next cycle, out_valid stays 1.
REQ-042 SHALL cover rst_n pulsed low with out_valid=1 -> out_valid=0, out=0, cc=100 immediately, without a clock edge.
REQ-043 SHALL cover WIDTH=8: add 0x7F+0x01 -> out=0x80, overflow=1, SF=1.
